// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-bit frame, device ACK check.
// Optional watchdog on device-driven waits is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_transmitter #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int INHIBIT_US     = 120,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    output logic       busy_o
);

    localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int INH_W          = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam int W_A            = (INH_W > 17) ? INH_W : 17;
    localparam int CNT_W          = (TO_W > W_A) ? TO_W : W_A;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(7);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, STOP, ACK_WAIT, WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       fall_cnt_q, fall_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_err_q, tx_err_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic clk_fall, lines_idle, accept;

    // Sync flops reset to the idle-high line level so reset release never fakes a fall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_fall   = clk_prev_q & ~clk_sync_q;
    assign lines_idle = clk_sync_q & data_sync_q;
    assign accept     = tx_valid_i & tx_ready_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        fall_cnt_d  = fall_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        data_oe_d   = data_oe_q;
        tx_done_d   = 1'b0;
        tx_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (accept) begin
                    shift_d     = {~^tx_data_i, tx_data_i};
                    fall_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    state_d     = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cycle_cnt_q == INHIBIT_LAST) begin
                    cycle_cnt_d = '0;
                    data_oe_d   = 1'b1;
                    state_d     = RTS;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
            end
            RTS: begin
                if (cycle_cnt_q == RTS_LAST) begin
                    cycle_cnt_d = '0;
                    state_d     = SEND;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
            end
            // The start bit stays on the line until fall 1; each fall then presents the next bit.
            SEND: begin
                if (clk_fall) begin
                    fall_cnt_d = fall_cnt_q + 4'd1;
                    if (fall_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = STOP;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                    end
                end
            end
            STOP: begin
                data_oe_d = 1'b0;
                if (clk_fall) begin
                    if (data_sync_q) begin
                        tx_err_d = 1'b1;
                        state_d  = WAIT_IDLE;
                    end else begin
                        state_d = ACK_WAIT;
                    end
                end
            end
            ACK_WAIT: begin
                data_oe_d = 1'b0;
                if (lines_idle) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (lines_idle) begin
                    state_d = IDLE;
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog restarts on any device activity; expiry abandons the frame.
        if (state_q inside {SEND, STOP, ACK_WAIT, WAIT_IDLE}) begin
            if (clk_fall || (state_d != state_q)) begin
                cycle_cnt_d = '0;
            end else if (cycle_cnt_q == TIMEOUT_LAST) begin
                cycle_cnt_d = '0;
                data_oe_d   = 1'b0;
                tx_done_d   = 1'b0;
                tx_err_d    = 1'b1;
                state_d     = IDLE;
            end else begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
        end
`endif

        clk_oe_d   = (state_d == INHIBIT) || (state_d == RTS);
        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            fall_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            fall_cnt_q  <= fall_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
            tx_err_q    <= tx_err_d;
        end
    end

    assign tx_ready_o    = tx_ready_q;
    assign busy_o        = busy_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;
    assign tx_done_o     = tx_done_q;
    assign tx_err_o      = tx_err_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a simple open-drain PS/2 device model.
// Covers the PS2_TX_TIMEOUT_EN watchdog when that macro is defined.
module tb_ps2_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    logic tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err, busy;
    logic ps2_clk_line, ps2_data_line;

    int total = 0;
    int bad = 0;
    int doneCount = 0;
    int errCount = 0;
    int bothCount = 0;

    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

`ifdef PS2_TX_TIMEOUT_EN
    ps2_transmitter #(.CLK_FREQ_HZ(50_000_000), .INHIBIT_US(120), .TIMEOUT_CYCLES(1000)) dut (
`else
    ps2_transmitter #(.CLK_FREQ_HZ(50_000_000), .INHIBIT_US(120), .TIMEOUT_CYCLES(1_000_000)) dut (
`endif
        .clk           (clk),
        .rst           (rst),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .ps2_clk_i     (ps2_clk_line),
        .ps2_data_i    (ps2_data_line),
        .ps2_clk_oe_o  (ps2_clk_oe),
        .ps2_data_oe_o (ps2_data_oe),
        .tx_done_o     (tx_done),
        .tx_err_o      (tx_err),
        .busy_o        (busy)
    );

    // Pulse monitor: each high cycle of a registered pulse is counted once.
    always @(posedge clk) begin
        if (tx_done) doneCount <= doneCount + 1;
        if (tx_err) errCount <= errCount + 1;
        if (tx_done && tx_err) bothCount <= bothCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic startFrame(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Counts cycles with the clock inhibited, and those before the start bit appears.
    task automatic waitRelease(output int clkLow, output int inhibit);
        clkLow  = 0;
        inhibit = 0;
        for (int i = 0; i < 10000 && ps2_clk_oe; i++) begin
            clkLow++;
            if (!ps2_data_oe) inhibit++;
            @(negedge clk);
        end
    endtask

    task automatic deviceFall(output logic bitSeen);
        dev_clk = 1'b0;
        waitCycles(20);
        bitSeen = ps2_data_line;
        dev_clk = 1'b1;
        waitCycles(20);
    endtask

    task automatic applyStimulus(input string name, input logic [7:0] b, input logic [8:0] expFrame,
                                 input bit ack, input bit midValid);
        int         d0;
        int         e0;
        int         clkLow;
        int         inhibit;
        logic [8:0] got;
        logic       bitSeen;
        d0 = doneCount;
        e0 = errCount;
        got = '0;
        startFrame(b);
        checkOutput({name, ".accept"}, {29'd0, tx_ready, busy, ps2_clk_oe}, 32'h3);
        waitRelease(clkLow, inhibit);
        checkOutput({name, ".clk_low_cycles"}, clkLow, 6008);
        checkOutput({name, ".inhibit_cycles"}, inhibit, 6000);
        checkOutput({name, ".start_bit"}, ps2_data_line, 0);
        waitCycles(5);
        for (int k = 0; k < 9; k++) begin
            deviceFall(bitSeen);
            got[k] = bitSeen;
            if (midValid && k == 3) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                waitCycles(4);
                checkOutput({name, ".ready_mid"}, tx_ready, 0);
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        end
        checkOutput({name, ".bits"}, got, expFrame);
        deviceFall(bitSeen);
        checkOutput({name, ".stop_bit"}, bitSeen, 1);
        dev_data = ack ? 1'b0 : 1'b1;
        waitCycles(5);
        dev_clk = 1'b0;
        waitCycles(20);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
        checkOutput({name, ".idle"}, {28'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 32'h8);
        waitCycles(2);
        checkOutput({name, ".done_pulses"}, doneCount - d0, ack ? 1 : 0);
        checkOutput({name, ".err_pulses"}, errCount - e0, ack ? 0 : 1);
        waitCycles(10);
    endtask

    initial begin
        int         clkLow;
        int         inhibit;
        int         n;
        logic       bitSeen;

        rst = 1'b0;
        waitCycles(3);
        checkOutput("reset", {26'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 32'h20);
        rst = 1'b1;
        waitCycles(5);

        // {parity, byte}: 0xED has six ones -> parity 1; 0x01 -> 0; 0xFF -> 1; 0x55 -> 1; 0xF4 -> 0.
        applyStimulus("ed", 8'hED, 9'h1ED, 1'b1, 1'b0);
        applyStimulus("x01", 8'h01, 9'h001, 1'b1, 1'b0);
        applyStimulus("xff", 8'hFF, 9'h1FF, 1'b1, 1'b0);
        applyStimulus("mid_valid", 8'h55, 9'h155, 1'b1, 1'b1);
        applyStimulus("nack", 8'hF4, 9'h0F4, 1'b0, 1'b0);

        startFrame(8'h00);
        waitRelease(clkLow, inhibit);
        waitCycles(5);
        repeat (3) deviceFall(bitSeen);
        checkOutput("rst_pre_data_oe", ps2_data_oe, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_frame", {28'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 32'h8);
        rst = 1'b1;
        waitCycles(10);

`ifdef PS2_TX_TIMEOUT_EN
        startFrame(8'h12);
        waitRelease(clkLow, inhibit);
        n = 0;
        while (!tx_err && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", n, 1000);
        checkOutput("timeout_idle", {28'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 32'h8);
        waitCycles(5);
`else
        n = 0;
`endif

        checkOutput("done_err_overlap", bothCount, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
